wishbone_mem_slave: RTL

//  Wishbone responder: single-port word-addressed RAM behind the interconnect

---
 rtl/wishbone_mem_slave_if.sv | 22 ++
 rtl/wishbone_mem_slave.sv | 119 +++++++++++
 2 files changed

// File: rtl/wishbone_mem_slave_if.sv
// rtl/wishbone_mem_slave_if.sv - Wishbone slave-side bus bundle for wishbone_mem_slave
interface wishbone_mem_slave_if;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_int_o;

  modport master (
    output wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_int_o
  );

  modport slave (
    input  wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_int_o
  );
endinterface

// File: rtl/wishbone_mem_slave.sv
// rtl/wishbone_mem_slave.sv - Wishbone RAM responder with programmable wait states
// Optional mailbox interrupt on the top word when WB_MEM_INT_EN is defined.
module wishbone_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 rst,
  wishbone_mem_slave_if.slave wb
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] MBOX_ADR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [31:0]             dat_q;
  logic [31:0]             rdat_q;
  logic [31:0]             mem [DEPTH];

  logic                    capture;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_adr;

  assign capture = (state == IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i;
  // With zero wait states ACK is entered straight from the bus, before the latch holds it
  assign req_we  = capture ? wb.wbs_we_i : we_q;
  assign req_adr = capture ? wb.wbs_adr_i[ADDR_WIDTH-1:0] : adr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        we_q  <= wb.wbs_we_i;
        sel_q <= wb.wbs_sel_i;
        adr_q <= wb.wbs_adr_i[ADDR_WIDTH-1:0];
        dat_q <= wb.wbs_dat_i;
      end
      rdat_q <= (state_nxt == ACK && !req_we) ? mem[req_adr] : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (capture) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS_CNT;
          end
        end
      end
      WAIT: begin
        if (!wb.wbs_cyc_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt <= 4'd1) begin
          state_nxt = ACK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK:     state_nxt = HOLD;
      HOLD:    if (!wb.wbs_stb_i || !wb.wbs_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb.wbs_ack_o = (state == ACK);
    wb.wbs_dat_o = rdat_q;
  end

  // A reset during ACK forces IDLE, so the pending write never reaches the array
  always_ff @(posedge clk) begin
    if (state == ACK && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[adr_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

`ifdef WB_MEM_INT_EN
  logic int_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_q <= 1'b0;
    end else if (state == ACK && adr_q == MBOX_ADR) begin
      int_q <= we_q;
    end
  end

  assign wb.wbs_int_o = int_q;
`else
  assign wb.wbs_int_o = 1'b0;
`endif

endmodule
